// File: rtl/cpx_spc_rpt_buf_if.sv
// CPX-to-SPARC repeater bus: crossbar-side packet/ready, core-side stall,
// delivered packet with its LSU bypass duplicate, and hold-buffer status.
interface cpx_spc_rpt_buf_if #(
    parameter int WIDTH = 145,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] cpx_spc_data_cx2;
    logic             cpx_spc_data_rdy_cx2;
    logic             spc_cpx_hold;
    logic [WIDTH-1:0] cpx_spc_data_cx3;
    logic             cpx_spc_data_rdy_cx3;
    logic [WIDTH-1:0] cpx_spc_data_cx3_dup;
    logic [CW-1:0]    buf_cnt;
    logic             buf_ovf;

    modport master (
        output cpx_spc_data_cx2,
        output cpx_spc_data_rdy_cx2,
        output spc_cpx_hold,
        input  cpx_spc_data_cx3,
        input  cpx_spc_data_rdy_cx3,
        input  cpx_spc_data_cx3_dup,
        input  buf_cnt,
        input  buf_ovf
    );

    modport slave (
        input  cpx_spc_data_cx2,
        input  cpx_spc_data_rdy_cx2,
        input  spc_cpx_hold,
        output cpx_spc_data_cx3,
        output cpx_spc_data_rdy_cx3,
        output cpx_spc_data_cx3_dup,
        output buf_cnt,
        output buf_ovf
    );
endinterface

// File: rtl/cpx_spc_rpt_buf.sv
// CPX-to-SPARC repeater: STAGES-deep register pipe feeding an output register,
// with an in-order hold buffer that absorbs packets while the core stalls.
module cpx_spc_rpt_buf #(
    parameter int WIDTH  = 145,
    parameter int STAGES = 2,
    parameter int DEPTH  = 4
) (
    input logic                 rclk,
    input logic                 reset,
    cpx_spc_rpt_buf_if.slave    bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic             w_tail_vld;
    logic [WIDTH-1:0] w_tail_data;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;
    logic             r_out_vld;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_dup_data;

    logic             w_enq;
    logic             w_deq;
    logic             w_drop;
    logic             w_out_vld_nxt;
    logic             w_out_load;
    logic [WIDTH-1:0] w_out_data_nxt;
    logic [CW-1:0]    w_cnt_nxt;

    generate
        if (STAGES == 1) begin : g_no_pipe
            assign w_tail_vld  = bus.cpx_spc_data_rdy_cx2;
            assign w_tail_data = bus.cpx_spc_data_cx2;
        end else begin : g_pipe
            logic [STAGES-2:0] r_vld;
            logic [WIDTH-1:0]  r_data [STAGES-1];

            // Pipe stages: valids always shift, data only follows a valid packet.
            always_ff @(posedge rclk or posedge reset) begin
                if (reset) begin
                    r_vld <= '0;
                    for (int i = 0; i < STAGES - 1; i++) begin
                        r_data[i] <= '0;
                    end
                end else begin
                    r_vld[0] <= bus.cpx_spc_data_rdy_cx2;
                    if (bus.cpx_spc_data_rdy_cx2) begin
                        r_data[0] <= bus.cpx_spc_data_cx2;
                    end
                    for (int i = 1; i < STAGES - 1; i++) begin
                        r_vld[i] <= r_vld[i-1];
                        if (r_vld[i-1]) begin
                            r_data[i] <= r_data[i-1];
                        end
                    end
                end
            end

            assign w_tail_vld  = r_vld[STAGES-2];
            assign w_tail_data = r_data[STAGES-2];
        end
    endgenerate

    // Output selection: stall, then buffer head, then tail pass-through.
    always_comb begin
        w_out_vld_nxt  = 1'b0;
        w_out_load     = 1'b0;
        w_out_data_nxt = w_tail_data;
        w_enq          = 1'b0;
        w_deq          = 1'b0;
        w_drop         = 1'b0;
        if (bus.spc_cpx_hold) begin
            if (w_tail_vld) begin
                if (r_cnt != FULL) begin
                    w_enq = 1'b1;
                end else begin
                    w_drop = 1'b1;
                end
            end else begin
                w_enq = 1'b0;
            end
        end else if (r_cnt != '0) begin
            // Head is freed this cycle, so a full buffer still accepts the tail.
            w_out_vld_nxt  = 1'b1;
            w_out_load     = 1'b1;
            w_out_data_nxt = r_mem[r_rd_ptr];
            w_deq          = 1'b1;
            w_enq          = w_tail_vld;
        end else begin
            w_out_vld_nxt  = w_tail_vld;
            w_out_load     = w_tail_vld;
            w_out_data_nxt = w_tail_data;
        end
    end

    // Occupancy next value from the enqueue/dequeue pair.
    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_enq, w_deq})
            2'b10:   w_cnt_nxt = r_cnt + CW'(1);
            2'b01:   w_cnt_nxt = r_cnt - CW'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Hold-buffer storage; contents are don't-care after reset.
    always_ff @(posedge rclk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= w_tail_data;
        end
    end

    // Buffer pointers, occupancy, sticky overflow and the output registers.
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_dup_data <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            r_cnt     <= w_cnt_nxt;
            r_out_vld <= w_out_vld_nxt;
            if (w_out_load) begin
                r_out_data <= w_out_data_nxt;
                r_dup_data <= w_out_data_nxt;
            end
        end
    end

    assign bus.cpx_spc_data_cx3     = r_out_data;
    assign bus.cpx_spc_data_rdy_cx3 = r_out_vld;
    assign bus.cpx_spc_data_cx3_dup = r_dup_data;
    assign bus.buf_cnt              = r_cnt;
    assign bus.buf_ovf              = r_ovf;
endmodule

// File: tb/tb_cpx_spc_rpt_buf.sv
// Randomised bench for cpx_spc_rpt_buf against a queue-based reference model
// of the repeater (delay line + FIFO of stalled packets).
module tb_cpx_spc_rpt_buf;
    localparam int WIDTH  = 145;
    localparam int STAGES = 2;
    localparam int DEPTH  = 4;

    logic rclk  = 1'b0;
    logic reset = 1'b1;

    cpx_spc_rpt_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    cpx_spc_rpt_buf #(.WIDTH(WIDTH), .STAGES(STAGES), .DEPTH(DEPTH)) dut (
        .rclk  (rclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] d;
    } pkt_t;

    int total = 0;
    int bad   = 0;

    pkt_t             delay_q[$];
    logic [WIDTH-1:0] stall_q[$];
    logic             exp_rdy;
    logic [WIDTH-1:0] exp_data;
    logic             exp_ovf;

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd_pkt();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[WIDTH-1:0];
    endfunction

    task automatic model_reset();
        pkt_t p;
        p.v = 1'b0;
        p.d = '0;
        delay_q.delete();
        for (int i = 0; i < STAGES - 1; i++) delay_q.push_back(p);
        stall_q.delete();
        exp_rdy  = 1'b0;
        exp_data = '0;
        exp_ovf  = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [WIDTH-1:0] d, input logic h);
        pkt_t p;
        pkt_t t;
        p.v = v;
        p.d = d;
        delay_q.push_back(p);
        t = delay_q.pop_front();
        if (h) begin
            exp_rdy = 1'b0;
            if (t.v) begin
                if (stall_q.size() < DEPTH) stall_q.push_back(t.d);
                else exp_ovf = 1'b1;
            end
        end else if (stall_q.size() > 0) begin
            exp_rdy  = 1'b1;
            exp_data = stall_q.pop_front();
            if (t.v) stall_q.push_back(t.d);
        end else begin
            exp_rdy = t.v;
            if (t.v) exp_data = t.d;
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".rdy"}, WIDTH'(bus.cpx_spc_data_rdy_cx3), WIDTH'(exp_rdy));
        check_eq({tag, ".data"}, bus.cpx_spc_data_cx3, exp_data);
        check_eq({tag, ".dup"}, bus.cpx_spc_data_cx3_dup, exp_data);
        check_eq({tag, ".cnt"}, WIDTH'(bus.buf_cnt), WIDTH'(stall_q.size()));
        check_eq({tag, ".ovf"}, WIDTH'(bus.buf_ovf), WIDTH'(exp_ovf));
    endtask

    task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] d, input logic h);
        bus.cpx_spc_data_rdy_cx2 = v;
        bus.cpx_spc_data_cx2     = d;
        bus.spc_cpx_hold         = h;
        @(posedge rclk);
        model_edge(v, d, h);
        #1;
        check_all(tag);
    endtask

    initial begin
        bus.cpx_spc_data_rdy_cx2 = 1'b0;
        bus.cpx_spc_data_cx2     = '0;
        bus.spc_cpx_hold         = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge rclk);
        reset = 1'b0;

        // Pass-through burst 1..5 then idle.
        for (int i = 1; i <= 5; i++) step("pass", 1'b1, WIDTH'(i), 1'b0);
        for (int i = 0; i < 4; i++) step("pass_idle", 1'b0, '0, 1'b0);

        // Stall three packets, then drain.
        for (int i = 0; i < 3; i++) step("stall", 1'b1, WIDTH'(16'hA0 + i), 1'b1);
        step("stall_last", 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) step("drain", 1'b0, '0, 1'b0);

        // Overflow: six packets into a four-entry buffer.
        for (int i = 1; i <= 6; i++) step("ovf_fill", 1'b1, WIDTH'(16'hB0 + i), 1'b1);
        step("ovf_tail", 1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) step("ovf_drain", 1'b0, '0, 1'b0);

        // Full buffer while a new packet arrives as hold drops.
        for (int i = 1; i <= 4; i++) step("full_fill", 1'b1, WIDTH'(16'hC0 + i), 1'b1);
        step("full_e", 1'b1, WIDTH'(16'hEE), 1'b1);
        step("full_rel", 1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) step("full_drain", 1'b0, '0, 1'b0);

        // Wrap-around: alternating stalls and releases of three packets.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 3; i++) step("wrap", 1'b1, rnd_pkt(), r[0] == 1'b0);
        end
        for (int i = 0; i < 6; i++) step("wrap_drain", 1'b0, '0, 1'b0);

        // Random traffic with bursty stalls.
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), rnd_pkt(), ($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 8; i++) step("rand_drain", 1'b0, '0, 1'b0);

        // Async reset mid-drain with three packets still buffered.
        for (int i = 1; i <= 4; i++) step("rst_fill", 1'b1, WIDTH'(16'hD0 + i), 1'b1);
        step("rst_tail", 1'b0, '0, 1'b1);
        step("rst_drain", 1'b0, '0, 1'b0);
        check_eq("rst_pre_cnt", WIDTH'(bus.buf_cnt), WIDTH'(3));
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_async_rdy", WIDTH'(bus.cpx_spc_data_rdy_cx3), WIDTH'(0));
        check_eq("rst_async_cnt", WIDTH'(bus.buf_cnt), WIDTH'(0));
        check_eq("rst_async_ovf", WIDTH'(bus.buf_ovf), WIDTH'(0));
        model_reset();
        @(negedge rclk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step("post_rst", 1'b0, '0, 1'b0);
        for (int i = 1; i <= 3; i++) step("post_rst_pass", 1'b1, rnd_pkt(), 1'b0);
        for (int i = 0; i < 3; i++) step("post_rst_idle", 1'b0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpx_spc_rpt_buf.md
# cpx_spc_rpt_buf

Parametrised CPX-to-SPARC repeater: carries the CPX return packet and its ready strobe from the crossbar edge to the core through a configurable number of register stages.
- Adds a small in-order hold buffer, so the core can stall packet delivery for a few cycles without losing packets.
- Drives a separately registered duplicate of the packet for LSU bypass loading.
- Reports buffer occupancy and a sticky overflow flag.

## Interface
- WIDTH, 145: CPX packet width in bits.
- STAGES, 2: register stages from input to output, including the output register; legal 1..4.
- DEPTH, 4: hold-buffer entries; power of two, legal 2..8.
- CW, $clog2(DEPTH+1): occupancy counter width (derived).

Ports:
- rclk  in  1  clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- cpx_spc_data_cx2  in  WIDTH  incoming packet.
- cpx_spc_data_rdy_cx2  in  1  packet valid.
- spc_cpx_hold  in  1  core stall request; while 1, no packet is delivered.
- cpx_spc_data_cx3  out  WIDTH  delivered packet (registered).
- cpx_spc_data_rdy_cx3  out  1  delivered-packet valid, one cycle per packet.
- cpx_spc_data_cx3_dup  out  WIDTH  duplicate output register, bit-identical to cpx_spc_data_cx3 every cycle (LSU bypass copy).
- buf_cnt  out  CW  hold-buffer occupancy, 0..DEPTH.
- buf_ovf  out  1  sticky: a packet was dropped.

## Operation
- **Pipe.** STAGES-1 registers precede the output register; the last one is the "tail".
  - With STAGES=1 the tail is the raw input pair.
  - Each pipe stage's valid bit always advances.
  - Each stage's data register loads only when the incoming valid is 1; otherwise it holds its old value.
- **Output register update, every cycle, by priority:**
  - hold=1: rdy_cx3<=0 and data_cx3 holds. A valid tail is enqueued if buf_cnt<DEPTH; otherwise it is dropped and buf_ovf<=1.
  - hold=0, buf_cnt>0: deliver the buffer head (rdy_cx3<=1, data<=head) and dequeue it. A valid tail is enqueued in the same cycle, so buf_cnt is unchanged. This holds even when buf_cnt==DEPTH; no drop occurs.
  - hold=0, buf_cnt==0: pass-through. rdy_cx3<=tail valid. data_cx3 loads the tail data only when the tail is valid.
- Delivery order is strictly arrival order; a buffered packet is never bypassed by a newer one.
- The buffer is a circular RAM with rd/wr pointers, each log2(DEPTH) bits. Pointers wrap modulo DEPTH.
- buf_cnt increments on enqueue-only, decrements on dequeue-only, and is unchanged on both or neither.
- buf_ovf clears only on reset.
- The dup register loads under exactly the same enable and value as data_cx3.

## Timing
- Reset values:
  - All valids 0, so rdy_cx3=0.
  - data_cx3, dup and all pipe data registers 0.
  - buf_cnt=0, buf_ovf=0, pointers 0.
  - Buffer RAM contents don't-care.
- Reset deassertion is synchronised externally. The first edge after deassertion is a normal cycle.
- Reset mid-operation: all in-flight and buffered packets are discarded; no partial delivery follows.
- Latency with buffer empty and hold=0: a packet valid at input at edge t appears at the output after edge t+STAGES-1, i.e. STAGES cycles of register delay. This equals the legacy single-stage repeater when STAGES=1.
- Back-to-back input is sustained at 1 packet/cycle in pass-through.
- hold is sampled at the same edge as the tail. A hold asserted in cycle c blocks that cycle's delivery: rdy_cx3=0 after edge c.
- After hold drops, buffered packets drain one per cycle starting at the next edge.
- Throughput never exceeds 1/cycle, so a continuous input stream after a stall keeps buf_cnt constant rather than draining it.
- The hold response is combinational from spc_cpx_hold to the output-register enable only; there is no combinational input-to-output path.

## Test plan
- **Pass-through:** STAGES=2, packets 0x1..0x5 on consecutive cycles, hold=0.
  - Required: rdy_cx3 high for 5 consecutive cycles starting 2 edges after the first input; data 0x1..0x5 in order.
  - dup equals data_cx3 every cycle; buf_cnt stays 0.
- **Stall and drain:** hold=1 for 3 cycles while 3 packets A,B,C arrive at the tail.
  - Required: rdy_cx3=0 during hold, buf_cnt=1,2,3.
  - After hold=0: A,B,C delivered on 3 consecutive cycles, buf_cnt=2,1,0, no ovf.
- **Overflow:** DEPTH=4, hold=1, 6 valid tail packets.
  - Required: buf_cnt saturates at 4 and buf_ovf=1 from the 5th drop edge onward.
  - After release exactly packets 1..4 are delivered; buf_ovf stays 1.
- **Full with simultaneous enqueue/dequeue:** buf_cnt=4, hold drops while a new packet E arrives.
  - Required: head delivered, E accepted, buf_cnt stays 4, no ovf.
  - The full drain order ends with E.
- **Wrap-around:** DEPTH=4, 10 stall/release cycles alternating 3 packets each.
  - Required: pointers wrap and every packet is delivered exactly once, in order.
- **Async reset mid-drain:** buf_cnt=3, assert reset between edges.
  - Required: rdy_cx3, buf_cnt, buf_ovf go to 0 immediately without a clock edge.
  - After release no stale packet is delivered.
